pipeline_if_stage: RTL and testbench
====================================

PIPELINE_IF_STAGE -- requirements
Module: pipeline_if_stage

Interface
REQ-001 Clock/reset SHALL be: one clock; reset is asynchronous and active-low.
REQ-002 Parameter RESET_PC, default 64'h0: PC fetched first after reset.
REQ-003 clk  in  1  rising-edge clock.
REQ-004 reset  in  1  asynchronous, active-low reset.
REQ-005 stall  in  1  downstream ID not accepting; output slot SHALL hold.
REQ-006 redirect_valid  in  1  EX-resolved jump/branch/mispredict; highest priority.
REQ-007 redirect_pc  in  64  target PC when redirect_valid=1.
REQ-008 imem_req  out  1  fetch request valid.
REQ-009 imem_addr  out  64  fetch address, stable while imem_req=1 and imem_ready=0, unless redirected.
REQ-010 imem_ready  in  1  request accepted this cycle when imem_req=1.
REQ-011 imem_rvalid  in  1  response data valid; at most one response per accepted request.
REQ-012 imem_rdata  in  32  fetched instruction.
REQ-013 instruction_IF  out  32  registered instruction to ID.
REQ-014 pc_IF  out  64  registered PC of instruction_IF.
REQ-015 valid_IF  out  1  instruction_IF is real (0 = bubble).
REQ-016 pred_taken_IF  out  1  fetch predicted this instruction taken.

Function
REQ-017 Internal fetch_pc register and 4-state FSM SHALL exist: REQ, WAIT, DROP, HOLD; max one outstanding request.
REQ-018 REQ: imem_req=1, imem_addr=fetch_pc; on imem_ready -> WAIT; redirect without accept -> fetch_pc=redirect_pc, stay REQ.
REQ-019 REQ with imem_ready and redirect same cycle -> DROP, fetch_pc=redirect_pc.
REQ-020 WAIT: imem_req=0; on imem_rvalid with slot free (valid_IF=0 or stall=0) -> load output regs, fetch_pc=next_pc, -> REQ.
REQ-021 WAIT: imem_rvalid while stall=1 and valid_IF=1 -> capture {rdata, pc} into hold buffer, -> HOLD.
REQ-022 WAIT: redirect (with or without rvalid) -> response discarded; no rvalid -> DROP, rvalid same cycle -> REQ; fetch_pc=redirect_pc.
REQ-023 DROP: imem_req=0; next imem_rvalid discarded, -> REQ; redirect in DROP SHALL update fetch_pc only.
REQ-024 HOLD: stall=0 -> hold buffer to output regs, -> REQ; redirect -> buffer discarded, -> REQ.
REQ-025 Output slot with stall=0 and no new instruction SHALL load bubble: valid_IF=0, instruction_IF=32'h00000013, pred_taken_IF=0.
REQ-026 Redirect SHALL clear output slot to bubble in the same edge, regardless of stall.
REQ-027 next_pc SHALL be pc+4 (64-bit, wraps modulo 2^64) unless prediction applies (REQ-031).
REQ-028 Latency: accept at cycle N, rvalid at N+k (k>=1), instruction visible at output after edge ending N+k; next imem_req at N+k+1.

Reset
REQ-029 reset=0 SHALL immediately force: state=REQ, fetch_pc=RESET_PC, instruction_IF=32'h00000013, pc_IF=0, valid_IF=0, pred_taken_IF=0, hold buffer invalid; imem_req=0 while reset=0.
REQ-030 Reset mid-transaction SHALL abandon the outstanding request; imem shares the same reset, no stale rvalid expected.

Configuration
REQ-031 Macro IF_BTFN_PREDICT_EN defined: on loading an instruction, opcode 1101111 (JAL) -> next_pc=pc+J-imm; opcode 1100011 with imm[12]=1 (backward) -> next_pc=pc+B-imm; pred_taken_IF=1 for both; otherwise pc+4, pred_taken_IF=0.
REQ-032 Macro absent: next_pc always pc+4, pred_taken_IF constant 0; redirect handling unchanged.

Verification
REQ-033 Reset release, RESET_PC=0x1000, imem 1-cycle: imem_addr 0x1000,0x1004,0x1008; pc_IF/valid_IF follow, one instruction per 2 cycles.
REQ-034 stall=1 while rvalid arrives (valid_IF=1): FSM->HOLD, outputs unchanged; stall=0 -> held instruction appears next edge, then REQ.
REQ-035 redirect_valid=1, redirect_pc=0x2000 in WAIT: next rvalid dropped, valid_IF=0 next edge, next imem_addr=0x2000.
REQ-036 redirect same cycle as imem_ready at 0x1008: DROP, response discarded, next imem_addr=redirect_pc.
REQ-037 IF_BTFN_PREDICT_EN, pc=0x1010, beq offset -16: next imem_addr=0x1000, pred_taken_IF=1; without macro: 0x1014, pred_taken_IF=0.
REQ-038 reset asserted in WAIT: outputs go to REQ-029 values asynchronously; after release imem_addr=RESET_PC.

Source files
------------

// File: rtl/pipeline_if_stage.sv
// Instruction-fetch stage: one outstanding imem request, registered IF/ID slot, stall hold buffer.
// Optional static backward-taken/forward-not-taken prediction when IF_BTFN_PREDICT_EN is defined.
module pipeline_if_stage #(
  parameter logic [63:0] RESET_PC = 64'h0
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        stall,
  input  logic        redirect_valid,
  input  logic [63:0] redirect_pc,
  output logic        imem_req,
  output logic [63:0] imem_addr,
  input  logic        imem_ready,
  input  logic        imem_rvalid,
  input  logic [31:0] imem_rdata,
  output logic [31:0] instruction_IF,
  output logic [63:0] pc_IF,
  output logic        valid_IF,
  output logic        pred_taken_IF
);
  localparam logic [31:0] NOP = 32'h0000_0013;

  typedef enum logic [1:0] {S_REQ, S_WAIT, S_DROP, S_HOLD} state_t;

  state_t      r_state, w_state_nxt;
  logic [63:0] r_fetch_pc, w_fetch_nxt;
  logic [31:0] r_ins, w_ins_nxt;
  logic [63:0] r_pc, w_pc_nxt;
  logic        r_vld, w_vld_nxt;
  logic        r_pred, w_pred_nxt;
  logic [31:0] r_hold_ins;
  logic [63:0] r_hold_pc;
  logic        r_hold_pred;
  logic        w_cap;
  logic        w_pred;
  logic [63:0] w_npc;

`ifdef IF_BTFN_PREDICT_EN
  logic [63:0] w_jimm, w_bimm;
  assign w_jimm = {{44{imem_rdata[31]}}, imem_rdata[19:12], imem_rdata[20],
                   imem_rdata[30:21], 1'b0};
  assign w_bimm = {{52{imem_rdata[31]}}, imem_rdata[7], imem_rdata[30:25],
                   imem_rdata[11:8], 1'b0};
`endif

  // Successor of the instruction currently returning from imem (always at r_fetch_pc).
  always_comb begin
    w_pred = 1'b0;
    w_npc  = r_fetch_pc + 64'd4;
`ifdef IF_BTFN_PREDICT_EN
    if (imem_rdata[6:0] == 7'b1101111) begin
      w_pred = 1'b1;
      w_npc  = r_fetch_pc + w_jimm;
    end else if (imem_rdata[6:0] == 7'b1100011 && imem_rdata[31]) begin
      w_pred = 1'b1;
      w_npc  = r_fetch_pc + w_bimm;
    end
`endif
  end

  always_comb begin
    w_state_nxt = r_state;
    w_fetch_nxt = r_fetch_pc;
    w_cap       = 1'b0;
    w_ins_nxt   = r_ins;
    w_pc_nxt    = r_pc;
    w_vld_nxt   = r_vld;
    w_pred_nxt  = r_pred;
    if (!stall) begin
      w_ins_nxt  = NOP;
      w_vld_nxt  = 1'b0;
      w_pred_nxt = 1'b0;
    end
    case (r_state)
      S_REQ: begin
        if (redirect_valid) begin
          w_fetch_nxt = redirect_pc;
          if (imem_ready) w_state_nxt = S_DROP;
        end else if (imem_ready) begin
          w_state_nxt = S_WAIT;
        end
      end
      S_WAIT: begin
        if (redirect_valid) begin
          w_fetch_nxt = redirect_pc;
          w_state_nxt = imem_rvalid ? S_REQ : S_DROP;
        end else if (imem_rvalid) begin
          w_fetch_nxt = w_npc;
          if (!r_vld || !stall) begin
            w_ins_nxt   = imem_rdata;
            w_pc_nxt    = r_fetch_pc;
            w_vld_nxt   = 1'b1;
            w_pred_nxt  = w_pred;
            w_state_nxt = S_REQ;
          end else begin
            w_cap       = 1'b1;
            w_state_nxt = S_HOLD;
          end
        end
      end
      S_DROP: begin
        if (redirect_valid) w_fetch_nxt = redirect_pc;
        if (imem_rvalid)    w_state_nxt = S_REQ;
      end
      S_HOLD: begin
        if (redirect_valid) begin
          w_fetch_nxt = redirect_pc;
          w_state_nxt = S_REQ;
        end else if (!stall) begin
          w_ins_nxt   = r_hold_ins;
          w_pc_nxt    = r_hold_pc;
          w_vld_nxt   = 1'b1;
          w_pred_nxt  = r_hold_pred;
          w_state_nxt = S_REQ;
        end
      end
      default: w_state_nxt = S_REQ;
    endcase
    // A redirect squashes whatever the slot would have held, even under stall.
    if (redirect_valid) begin
      w_ins_nxt  = NOP;
      w_vld_nxt  = 1'b0;
      w_pred_nxt = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state    <= S_REQ;
      r_fetch_pc <= RESET_PC;
      r_ins      <= NOP;
      r_pc       <= 64'h0;
      r_vld      <= 1'b0;
      r_pred     <= 1'b0;
    end else begin
      r_state    <= w_state_nxt;
      r_fetch_pc <= w_fetch_nxt;
      r_ins      <= w_ins_nxt;
      r_pc       <= w_pc_nxt;
      r_vld      <= w_vld_nxt;
      r_pred     <= w_pred_nxt;
    end
  end

  // Buffer contents are only meaningful in S_HOLD; leaving that state invalidates them.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_hold_ins  <= NOP;
      r_hold_pc   <= 64'h0;
      r_hold_pred <= 1'b0;
    end else if (w_cap) begin
      r_hold_ins  <= imem_rdata;
      r_hold_pc   <= r_fetch_pc;
      r_hold_pred <= w_pred;
    end
  end

  assign imem_req       = (r_state == S_REQ) && reset;
  assign imem_addr      = r_fetch_pc;
  assign instruction_IF = r_ins;
  assign pc_IF          = r_pc;
  assign valid_IF       = r_vld;
  assign pred_taken_IF  = r_pred;
endmodule

// File: tb/tb_pipeline_if_stage.sv
// Bench for pipeline_if_stage: transaction-level model plus imem responder, directed then random.
module tb_pipeline_if_stage;
  localparam logic [63:0] RPC = 64'h1000;
  localparam logic [31:0] NOP = 32'h0000_0013;

  logic        clk = 1'b0, reset = 1'b0, stall = 1'b0, redirect_valid = 1'b0;
  logic [63:0] redirect_pc = 64'h0;
  logic        imem_ready = 1'b0, imem_rvalid = 1'b0;
  logic [31:0] imem_rdata = 32'h0;
  logic        imem_req, valid_IF, pred_taken_IF;
  logic [63:0] imem_addr, pc_IF;
  logic [31:0] instruction_IF;

  pipeline_if_stage #(.RESET_PC(RPC)) dut (
    .clk(clk), .reset(reset), .stall(stall), .redirect_valid(redirect_valid),
    .redirect_pc(redirect_pc), .imem_req(imem_req), .imem_addr(imem_addr),
    .imem_ready(imem_ready), .imem_rvalid(imem_rvalid), .imem_rdata(imem_rdata),
    .instruction_IF(instruction_IF), .pc_IF(pc_IF), .valid_IF(valid_IF),
    .pred_taken_IF(pred_taken_IF)
  );

  always #5 clk = ~clk;

  int checks = 0, errors = 0;

  // Model: busy = a request is in flight, drop = its response will be discarded,
  // held = a fetched instruction waits for the slot.
  logic        m_busy, m_drop, m_held, m_vld, m_pred, m_hpred;
  logic [31:0] m_ins, m_hins;
  logic [63:0] m_fetch, m_pc, m_hpc;
  logic        mem_pend;
  int          mem_cnt, lat;
  logic [63:0] mem_addr;

  function automatic logic [31:0] ins_of(input logic [63:0] a);
    if (a == 64'h1010) return 32'hFE0008E3;  // beq x0,x0,-16
    return {a[26:2] ^ 25'h15A5A5A, 7'h33};
  endfunction

  function automatic logic [64:0] predict(input logic [31:0] ins, input logic [63:0] pc);
    logic en;
    logic signed [63:0] off;
`ifdef IF_BTFN_PREDICT_EN
    en = 1'b1;
`else
    en = 1'b0;
`endif
    if (en && ins[6:0] == 7'b1101111) begin
      off = 64'($signed({ins[31], ins[19:12], ins[20], ins[30:21], 1'b0}));
      return {1'b1, pc + off};
    end
    if (en && ins[6:0] == 7'b1100011 && ins[31]) begin
      off = 64'($signed({ins[31], ins[7], ins[30:25], ins[11:8], 1'b0}));
      return {1'b1, pc + off};
    end
    return {1'b0, pc + 64'd4};
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic check_all();
    logic req;
    req = !m_busy && !m_held;
    check("imem_req", 64'(imem_req), 64'(req));
    if (req) check("imem_addr", imem_addr, m_fetch);
    check("instruction_IF", 64'(instruction_IF), 64'(m_ins));
    check("valid_IF", 64'(valid_IF), 64'(m_vld));
    check("pred_taken_IF", 64'(pred_taken_IF), 64'(m_pred));
    if (m_vld) check("pc_IF", pc_IF, m_pc);
  endtask

  task automatic model_reset();
    m_busy = 0; m_drop = 0; m_held = 0; m_vld = 0; m_pred = 0;
    m_ins = NOP; m_pc = 64'h0; m_fetch = RPC;
    mem_pend = 0; mem_cnt = 0; imem_rvalid = 0;
  endtask

  task automatic bubble();
    m_vld = 0; m_ins = NOP; m_pred = 0;
  endtask

  // One clock: memory drives its response, model advances at the edge, compare at negedge.
  task automatic step();
    logic acc;
    logic [63:0] f0;
    logic [64:0] pr;
    imem_rvalid = mem_pend && mem_cnt == 0;
    imem_rdata  = imem_rvalid ? ins_of(mem_addr) : 32'h0;
    acc = !m_busy && !m_held && imem_ready;
    f0  = m_fetch;
    @(posedge clk);
    if (redirect_valid) begin
      bubble();
      m_fetch = redirect_pc;
      m_held  = 0;
      if (acc) begin m_busy = 1; m_drop = 1; end
      else if (m_busy && imem_rvalid) begin m_busy = 0; m_drop = 0; end
      else if (m_busy) m_drop = 1;
    end else if (acc) begin
      m_busy = 1; m_drop = 0;
      if (!stall) bubble();
    end else if (m_busy && imem_rvalid) begin
      m_busy = 0;
      if (m_drop) begin
        m_drop = 0;
        if (!stall) bubble();
      end else begin
        pr = predict(imem_rdata, m_fetch);
        if (!m_vld || !stall) begin
          m_ins = imem_rdata; m_pc = m_fetch; m_vld = 1; m_pred = pr[64];
        end else begin
          m_held = 1; m_hins = imem_rdata; m_hpc = m_fetch; m_hpred = pr[64];
        end
        m_fetch = pr[63:0];
      end
    end else if (m_held && !stall) begin
      m_ins = m_hins; m_pc = m_hpc; m_vld = 1; m_pred = m_hpred; m_held = 0;
    end else if (!stall) begin
      bubble();
    end
    if (imem_rvalid) mem_pend = 0;
    else if (mem_pend && mem_cnt > 0) mem_cnt--;
    if (acc) begin mem_pend = 1; mem_addr = f0; mem_cnt = lat - 1; end
    @(negedge clk);
    check_all();
  endtask

  // Reset asserted between edges: outputs must change without waiting for a clock.
  task automatic do_reset();
    reset = 0;
    redirect_valid = 0;
    #1;
    check("rst valid_IF", 64'(valid_IF), 64'h0);
    check("rst instruction_IF", 64'(instruction_IF), 64'(NOP));
    check("rst pc_IF", pc_IF, 64'h0);
    check("rst imem_req", 64'(imem_req), 64'h0);
    check("rst pred_taken_IF", 64'(pred_taken_IF), 64'h0);
    model_reset();
    @(negedge clk);
    reset = 1;
    #1;
    check("post-rst imem_req", 64'(imem_req), 64'h1);
    check("post-rst imem_addr", imem_addr, RPC);
  endtask

  initial begin
    lat = 1;
    model_reset();
    @(negedge clk);
    do_reset();
    imem_ready = 1;
    // Back-to-back fetch with 1-cycle memory: one instruction every two cycles.
    step(); check("d33 wait req", 64'(imem_req), 64'h0);
    step(); check("d33 pc0", pc_IF, 64'h1000); check("d33 addr1", imem_addr, 64'h1004);
    step(); step();
    check("d33 pc1", pc_IF, 64'h1004); check("d33 addr2", imem_addr, 64'h1008);
    check("d33 valid", 64'(valid_IF), 64'h1);
    // Redirect coincident with acceptance: response dropped.
    redirect_valid = 1; redirect_pc = 64'h2000;
    step(); redirect_valid = 0;
    check("d36 drop req", 64'(imem_req), 64'h0);
    check("d36 bubble", 64'(valid_IF), 64'h0);
    step(); check("d36 addr", imem_addr, 64'h2000); check("d36 valid", 64'(valid_IF), 64'h0);
    // Redirect while waiting on a 2-cycle response.
    lat = 2;
    step();
    redirect_valid = 1; redirect_pc = 64'h3000;
    step(); redirect_valid = 0;
    check("d35 valid", 64'(valid_IF), 64'h0); check("d35 req", 64'(imem_req), 64'h0);
    step(); check("d35 addr", imem_addr, 64'h3000); check("d35 req2", 64'(imem_req), 64'h1);
    // Response arrives during stall with a valid slot: held, then released.
    lat = 1;
    step(); step(); check("d34 pc", pc_IF, 64'h3000);
    stall = 1;
    step(); step();
    check("d34 hold pc", pc_IF, 64'h3000); check("d34 hold req", 64'(imem_req), 64'h0);
    step(); check("d34 still", pc_IF, 64'h3000);
    stall = 0;
    step();
    check("d34 rel pc", pc_IF, 64'h3004); check("d34 rel addr", imem_addr, 64'h3008);
    // Backward branch at 0x1010.
    imem_ready = 0; redirect_valid = 1; redirect_pc = 64'h1010;
    step(); redirect_valid = 0; imem_ready = 1;
    step(); step();
    check("d37 pc", pc_IF, 64'h1010);
`ifdef IF_BTFN_PREDICT_EN
    check("d37 addr", imem_addr, 64'h1000); check("d37 pred", 64'(pred_taken_IF), 64'h1);
`else
    check("d37 addr", imem_addr, 64'h1014); check("d37 pred", 64'(pred_taken_IF), 64'h0);
`endif
    // Reset while a request is outstanding.
    step(); do_reset();

    for (int i = 0; i < 4000; i++) begin
      stall          = ($urandom % 2) == 0;
      imem_ready     = ($urandom % 10) < 7;
      redirect_valid = ($urandom % 16) == 0;
      lat            = $urandom_range(1, 3);
      case ($urandom % 3)
        0: redirect_pc = 64'hFFFF_FFFF_FFFF_FFF0 + 64'(4 * $urandom_range(0, 3));
        1: redirect_pc = 64'(32'h1000 + 4 * $urandom_range(0, 15));
        default: redirect_pc = {$urandom, $urandom} & ~64'h3;
      endcase
      if (($urandom % 300) == 0) do_reset();
      else step();
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
